// File: rtl/sha256_input_padder_pkg.sv
// Shared definitions for the SHA-256 input padder: core block-op fields, pad constants,
// length word addresses, FSM state encoding and a word byte-swap helper.
package sha256_input_padder_pkg;

  localparam int unsigned BLK_OP_MSB             = 1;
  localparam int unsigned BLK_OP_NEW_CTX         = 0;
  localparam int unsigned BLK_OP_END_COMP_OUTPUT = 1;

  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

  localparam logic [3:0] LAST_ZERO_ADDR = 4'd13;
  localparam logic [3:0] LEN_HI_ADDR    = 4'd14;
  localparam logic [3:0] LEN_LO_ADDR    = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_DATA,
    ST_PAD,
    ST_ZERO,
    ST_LEN_HI,
    ST_LEN_LO
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_pad_merge.sv
// Combinational helper: keeps the valid bytes of the final message word, inserts the
// 0x80 pad byte right after them, and byte-swaps the bit length into core word order.
module sha256_pad_merge
  import sha256_input_padder_pkg::*;
(
  input  logic [31:0] din,
  input  logic [2:0]  nbytes,
  input  logic [31:0] len_in,
  output logic [31:0] merged,
  output logic [31:0] len_out
);

  // nbytes == 4 passes the word through untouched (pad goes into a later word)
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < nbytes) begin
        merged[8*i +: 8] = din[8*i +: 8];
      end else if (3'(i) == nbytes) begin
        merged[8*i +: 8] = SHA256_PAD_BYTE;
      end
    end
  end

  assign len_out = bswap32(len_in);

endmodule

// File: rtl/sha256_input_padder.sv
// SHA-256 message padder feeding the sha256core input buffer in 16-word blocks.
// Optional SHA256_PADDER_LEN_CHECK_EN: saturating byte count with sticky err.
module sha256_input_padder
  import sha256_input_padder_pkg::*;
#(
  parameter int unsigned MSG_LEN_MSB = 12
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [31:0]         src_din,
  input  logic                src_wr_en,
  input  logic                src_last,
  input  logic [2:0]          src_bytes,
  input  logic                src_ctx,
  input  logic                src_seq,
  input  logic                src_output,
  output logic                src_rdy,
  input  logic [3:0]          core_ready,
  output logic                wr_en,
  output logic [31:0]         dout,
  output logic [3:0]          wr_addr,
  output logic [BLK_OP_MSB:0] input_blk_op,
  output logic                input_ctx,
  output logic                input_seq,
  output logic                set_input_ready,
  output logic                busy,
  output logic                err
);

  localparam int unsigned LW = MSG_LEN_MSB + 1;
`ifdef SHA256_PADDER_LEN_CHECK_EN
  localparam logic [LW:0] MAX_BYTES = {1'b0, {LW{1'b1}}};
  logic [LW:0] sum;
`endif

  state_e              state_q, state_d, resume_q, resume_d;
  logic                wait_first_q, wait_first_d;
  logic [3:0]          addr_q, addr_d;
  logic [LW-1:0]       bytes_q, bytes_d;
  logic                ctx_q, ctx_d, seq_q, seq_d, out_q, out_d;
  logic                new_ctx_q, new_ctx_d, fin_q, fin_d, err_q, err_d;
  logic                wr_en_q, wr_en_d, sir_q, sir_d;
  logic [31:0]         dout_q, dout_d;
  logic [3:0]          wr_addr_q, wr_addr_d;
  logic [BLK_OP_MSB:0] blk_op_q, blk_op_d;

  logic                do_write, pad_placed, drop, blk_fin;
  logic [31:0]         wdata, merged, len_word, bitlen;
  logic [2:0]          tail_nb;
  state_e              close_to;

  assign tail_nb = (src_last && (src_bytes < 3'd4)) ? src_bytes : 3'd4;
  assign bitlen  = 32'({bytes_q, 3'b000});

  sha256_pad_merge u_pad_merge (
    .din     (src_din),
    .nbytes  (tail_nb),
    .len_in  (bitlen),
    .merged  (merged),
    .len_out (len_word)
  );

  always_comb begin
    state_d      = state_q;
    resume_d     = resume_q;
    wait_first_d = wait_first_q;
    addr_d       = addr_q;
    bytes_d      = bytes_q;
    ctx_d        = ctx_q;
    seq_d        = seq_q;
    out_d        = out_q;
    new_ctx_d    = new_ctx_q;
    fin_d        = fin_q;
    err_d        = err_q;
    wr_en_d      = 1'b0;
    sir_d        = 1'b0;
    dout_d       = dout_q;
    wr_addr_d    = wr_addr_q;
    blk_op_d     = blk_op_q;
    do_write     = 1'b0;
    pad_placed   = 1'b0;
    drop         = 1'b0;
    blk_fin      = fin_q;
    wdata        = '0;
    close_to     = ST_DATA;
`ifdef SHA256_PADDER_LEN_CHECK_EN
    sum          = '0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (src_wr_en) begin
          ctx_d        = src_ctx;
          seq_d        = src_seq;
          out_d        = src_output;
          new_ctx_d    = 1'b1;
          fin_d        = 1'b0;
          bytes_d      = '0;
          addr_d       = '0;
          resume_d     = ST_DATA;
          wait_first_d = 1'b1;
          state_d      = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        // the core's ready bit lags one cycle behind set_input_ready
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (core_ready[{seq_q, ctx_q}]) begin
          state_d = resume_q;
        end
      end
      ST_DATA: begin
        if (src_wr_en) begin
`ifdef SHA256_PADDER_LEN_CHECK_EN
          sum = {1'b0, bytes_q} + (LW+1)'(tail_nb);
          if (err_q || (sum > MAX_BYTES)) begin
            drop    = 1'b1;
            err_d   = 1'b1;
            bytes_d = MAX_BYTES[LW-1:0];
          end else begin
            bytes_d = sum[LW-1:0];
          end
`else
          bytes_d = bytes_q + LW'(tail_nb);
`endif
          do_write = !drop;
          wdata    = merged;
          if (src_last) begin
            if (!drop && (tail_nb != 3'd4)) begin
              pad_placed = 1'b1;
            end else begin
              state_d  = ST_PAD;
              close_to = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        do_write   = 1'b1;
        wdata      = {24'h0, SHA256_PAD_BYTE};
        pad_placed = 1'b1;
      end
      ST_ZERO: begin
        do_write = 1'b1;
        close_to = ST_ZERO;
        if (addr_q == LAST_ZERO_ADDR) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        do_write = 1'b1;
        state_d  = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        do_write = 1'b1;
        wdata    = len_word;
        state_d  = ST_IDLE;
        fin_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // a block holds the length iff its 0x80 lands at addr 13 or below
    if (pad_placed) begin
      close_to = ST_ZERO;
      if (addr_q <= LAST_ZERO_ADDR) begin
        fin_d   = 1'b1;
        blk_fin = 1'b1;
      end
      if (addr_q == LAST_ZERO_ADDR) begin
        state_d = ST_LEN_HI;
      end else if (addr_q != LEN_LO_ADDR) begin
        state_d = ST_ZERO;
      end
    end

    if (do_write) begin
      wr_en_d   = 1'b1;
      dout_d    = wdata;
      wr_addr_d = addr_q;
      addr_d    = addr_q + 4'd1;
      blk_op_d  = '0;
      blk_op_d[BLK_OP_NEW_CTX]         = new_ctx_q;
      blk_op_d[BLK_OP_END_COMP_OUTPUT] = out_q & blk_fin;
      if (addr_q == LEN_LO_ADDR) begin
        sir_d     = 1'b1;
        new_ctx_d = 1'b0;
        if (state_q != ST_LEN_LO) begin
          state_d      = ST_WAIT_RDY;
          wait_first_d = 1'b1;
          resume_d     = close_to;
          fin_d        = (close_to == ST_ZERO);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      resume_q     <= ST_DATA;
      wait_first_q <= 1'b0;
      addr_q       <= '0;
      bytes_q      <= '0;
      ctx_q        <= 1'b0;
      seq_q        <= 1'b0;
      out_q        <= 1'b0;
      new_ctx_q    <= 1'b0;
      fin_q        <= 1'b0;
      err_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      sir_q        <= 1'b0;
      dout_q       <= '0;
      wr_addr_q    <= '0;
      blk_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      wait_first_q <= wait_first_d;
      addr_q       <= addr_d;
      bytes_q      <= bytes_d;
      ctx_q        <= ctx_d;
      seq_q        <= seq_d;
      out_q        <= out_d;
      new_ctx_q    <= new_ctx_d;
      fin_q        <= fin_d;
      err_q        <= err_d;
      wr_en_q      <= wr_en_d;
      sir_q        <= sir_d;
      dout_q       <= dout_d;
      wr_addr_q    <= wr_addr_d;
      blk_op_q     <= blk_op_d;
    end
  end

  assign src_rdy         = (state_q == ST_DATA);
  assign busy            = (state_q != ST_IDLE);
  assign wr_en           = wr_en_q;
  assign dout            = dout_q;
  assign wr_addr         = wr_addr_q;
  assign input_blk_op    = blk_op_q;
  assign input_ctx       = ctx_q;
  assign input_seq       = seq_q;
  assign set_input_ready = sir_q;
  assign err             = err_q;

endmodule

// File: tb/tb_sha256_input_padder.sv
// Directed bench for sha256_input_padder: per-message write logs checked against a table.
module tb_sha256_input_padder;

`ifdef SHA256_PADDER_LEN_CHECK_EN
  localparam int unsigned MLM = 5;
`else
  localparam int unsigned MLM = 12;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] src_din;
  logic        src_wr_en, src_last, src_ctx, src_seq, src_output;
  logic [2:0]  src_bytes;
  logic        src_rdy;
  logic [3:0]  core_ready;
  logic        wr_en;
  logic [31:0] dout;
  logic [3:0]  wr_addr;
  logic [1:0]  input_blk_op;
  logic        input_ctx, input_seq, set_input_ready, busy, err;

  sha256_input_padder #(.MSG_LEN_MSB(MLM)) dut (
    .CLK(CLK), .reset(reset), .src_din(src_din), .src_wr_en(src_wr_en),
    .src_last(src_last), .src_bytes(src_bytes), .src_ctx(src_ctx), .src_seq(src_seq),
    .src_output(src_output), .src_rdy(src_rdy), .core_ready(core_ready),
    .wr_en(wr_en), .dout(dout), .wr_addr(wr_addr), .input_blk_op(input_blk_op),
    .input_ctx(input_ctx), .input_seq(input_seq), .set_input_ready(set_input_ready),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          t;
    int          idx;
    logic [3:0]  addr;
    logic [31:0] data;
    bit          chk_op;
    logic [1:0]  op;
    bit          sir;
  } chk_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
    logic        sir;
  } wr_t;

  chk_t tbl[$];
  wr_t  wr_log[$];
  int   sir_cnt = 0;
  int   sir_base = 0;
  int   n_pass = 0;
  int   n_total = 0;

  logic [31:0] hello_w [9] = '{32'h6c6c6548, 32'h6f77206f, 32'h21646c72, 32'h746c6173,
                               32'h69727473, 32'h6548676e, 32'h206f6c6c, 32'h6c726f77,
                               32'h00002164};

  always @(negedge CLK) begin
    if (wr_en) wr_log.push_back('{wr_addr, dout, input_blk_op, set_input_ready});
    if (set_input_ready) sir_cnt++;
  end

  function automatic logic [31:0] gen_word(input int i);
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  function automatic void add(input int t, input int idx, input logic [3:0] a,
                              input logic [31:0] d, input bit co, input logic [1:0] op,
                              input bit s);
    tbl.push_back('{t, idx, a, d, co, op, s});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic push(input logic [31:0] w, input logic last, input logic [2:0] nb,
                      output bit ok);
    ok = 1'b0;
    src_din = w; src_last = last; src_bytes = nb; src_wr_en = 1'b1;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge CLK);
      if (src_rdy) begin
        @(posedge CLK);
        #1;
        ok = 1'b1;
      end
    end
    src_wr_en = 1'b0; src_last = 1'b0;
  endtask

  task automatic wait_idle(input int t);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge CLK);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL t%0d_idle: busy still 1 after 1000 cycles, expected 0", t);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic send_msg(input int t, input int nw, input logic [2:0] lb, input logic c,
                          input logic s, input logic o, input bit hello);
    bit ok;
    src_ctx = c; src_seq = s; src_output = o;
    for (int i = 0; i < nw; i++) begin
      push(hello ? hello_w[i] : gen_word(i), (i == nw - 1), lb, ok);
      if (!ok) begin
        n_total++;
        $display("FAIL t%0d_accept: word %0d not accepted within 1000 cycles", t, i);
        return;
      end
    end
    wait_idle(t);
  endtask

  task automatic start_test();
    wr_log.delete();
    sir_base = sir_cnt;
  endtask

  task automatic check_test(input int t, input int exp_n, input int exp_sir);
    int          bad;
    logic [63:0] act, expv;
    wr_t         w;
    bad = 0;
    check($sformatf("t%0d_writes", t), 64'(wr_log.size()), 64'(exp_n));
    check($sformatf("t%0d_sir_count", t), 64'(sir_cnt - sir_base), 64'(exp_sir));
    foreach (wr_log[i]) if (wr_log[i].addr != 4'(i)) bad++;
    check($sformatf("t%0d_addr_seq", t), 64'(bad), 64'd0);
    foreach (tbl[k]) begin
      if (tbl[k].t == t) begin
        if (tbl[k].idx < wr_log.size()) begin
          w    = wr_log[tbl[k].idx];
          act  = {25'h0, w.sir, (tbl[k].chk_op ? w.op : tbl[k].op), w.addr, w.data};
          expv = {25'h0, tbl[k].sir, tbl[k].op, tbl[k].addr, tbl[k].data};
          check($sformatf("t%0d_w%0d{sir,op,addr,data}", t, tbl[k].idx), act, expv);
        end else begin
          n_total++;
          $display("FAIL t%0d_w%0d: write missing, got %0d writes", t, tbl[k].idx,
                   wr_log.size());
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int viol;

    // op = {END_COMP_OUTPUT, NEW_CTX}
    add(1, 0,  4'd0,  32'h6c6c6548, 0, 2'd0, 0);
    add(1, 7,  4'd7,  32'h6c726f77, 0, 2'd0, 0);
    add(1, 8,  4'd8,  32'h00802164, 1, 2'd3, 0);
    add(1, 9,  4'd9,  32'h00000000, 0, 2'd0, 0);
    add(1, 14, 4'd14, 32'h00000000, 0, 2'd0, 0);
    add(1, 15, 4'd15, 32'h10010000, 1, 2'd3, 1);
    add(2, 13, 4'd13, 32'h37363534, 0, 2'd0, 0);
    add(2, 14, 4'd14, 32'h00000080, 1, 2'd1, 0);
    add(2, 15, 4'd15, 32'h00000000, 1, 2'd1, 1);
    add(2, 16, 4'd0,  32'h00000000, 1, 2'd2, 0);
    add(2, 30, 4'd14, 32'h00000000, 0, 2'd0, 0);
    add(2, 31, 4'd15, 32'hC0010000, 1, 2'd2, 1);
    add(3, 0,  4'd0,  32'h03020100, 1, 2'd1, 0);
    add(3, 15, 4'd15, 32'h3f3e3d3c, 1, 2'd1, 1);
    add(3, 16, 4'd0,  32'h00000080, 1, 2'd0, 0);
    add(3, 17, 4'd1,  32'h00000000, 0, 2'd0, 0);
    add(3, 31, 4'd15, 32'h00020000, 1, 2'd0, 1);
    add(4, 1,  4'd1,  32'h07060504, 1, 2'd1, 0);
    add(4, 2,  4'd2,  32'h00000080, 1, 2'd3, 0);
    add(4, 15, 4'd15, 32'h40000000, 1, 2'd3, 1);
    add(5, 0,  4'd0,  32'h03020100, 1, 2'd1, 0);
    add(5, 1,  4'd1,  32'h00000080, 0, 2'd0, 0);
    add(5, 15, 4'd15, 32'h20000000, 1, 2'd1, 1);
    add(6, 14, 4'd14, 32'h3b3a3938, 0, 2'd0, 0);
    add(6, 15, 4'd15, 32'h00000080, 1, 2'd1, 1);
    add(6, 16, 4'd0,  32'h00000000, 1, 2'd2, 0);
    add(6, 31, 4'd15, 32'hF8010000, 1, 2'd2, 1);

    reset = 1'b1; src_din = '0; src_wr_en = 1'b0; src_last = 1'b0; src_bytes = 3'd4;
    src_ctx = 1'b0; src_seq = 1'b0; src_output = 1'b0; core_ready = 4'hF;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", 64'({src_rdy, wr_en, dout, wr_addr, input_blk_op, input_ctx,
                                input_seq, set_input_ready, busy, err}), 64'd0);
    @(posedge CLK); #1;
    reset = 1'b0;

    // 1: 34-byte string, pad merged into last word
    start_test();
    send_msg(1, 9, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    check_test(1, 16, 1);

    // 2: 56 bytes, pad at addr 14 forces a length-only second block
    start_test();
    send_msg(2, 14, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    check_test(2, 32, 2);
    check("t2_ctx_seq", 64'({input_ctx, input_seq}), 64'b10);

`ifndef SHA256_PADDER_LEN_CHECK_EN
    // 3: 64 bytes, full last word at addr 15, pad at addr 0 of block 2
    start_test();
    send_msg(3, 16, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    check_test(3, 32, 2);
`endif

    // 4: core not ready for {seq,ctx}=3 for 50 cycles
    start_test();
    core_ready = 4'b0111;
    src_ctx = 1'b1; src_seq = 1'b1; src_output = 1'b1;
    src_din = gen_word(0); src_last = 1'b0; src_bytes = 3'd4; src_wr_en = 1'b1;
    viol = 0;
    repeat (50) begin
      @(negedge CLK);
      if (src_rdy || wr_en) viol++;
    end
    check("t4_stall_quiet", 64'(viol), 64'd0);
    check("t4_stall_busy", 64'(busy), 64'd1);
    core_ready = 4'hF;
    send_msg(4, 2, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    check_test(4, 16, 1);

    // 5: reset right after the addr-6 write, then a fresh message
    start_test();
    src_ctx = 1'b1; src_seq = 1'b0; src_output = 1'b1;
    for (int i = 0; i < 7; i++) push(gen_word(i), 1'b0, 3'd4, ok);
    reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("t5_pre_reset_writes", 64'(wr_log.size()), 64'd7);
    if (wr_log.size() > 0) check("t5_last_addr", 64'(wr_log[wr_log.size()-1].addr), 64'd6);
    check("t5_reset_outputs", 64'({src_rdy, wr_en, dout, wr_addr, input_blk_op, input_ctx,
                                   input_seq, set_input_ready, busy}), 64'd0);
    check("t5_no_sir", 64'(sir_cnt - sir_base), 64'd0);
    @(posedge CLK); #1;
    reset = 1'b0;
    start_test();
    send_msg(5, 1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    check_test(5, 16, 1);

`ifdef SHA256_PADDER_LEN_CHECK_EN
    // 6: 68 bytes against a 63-byte limit
    start_test();
    check("t6_err_clear", 64'(err), 64'd0);
    send_msg(6, 17, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    check_test(6, 32, 2);
    check("t6_err", 64'(err), 64'd1);
`else
    check("err_disabled", 64'(err), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
